axi4_stream_pkt_arb: RTL and testbench

AXI4_STREAM_PKT_ARB -- requirements
Module: axi4_stream_pkt_arb

---
 rtl/axi4_stream_pkt_arb.sv | 140 ++++++++++++++
 tb/tb_axi4_stream_pkt_arb.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_pkt_arb.sv
// Round-robin packet arbiter: grants one AXI4-Stream source per packet, holds the grant
// until tlast, and latches that source's fragment size for the downstream fragmenter.
module axi4_stream_pkt_arb #(
    parameter  int unsigned N_SRC               = 4,
    parameter  int unsigned TDATA_WIDTH         = 64,
    parameter  int unsigned TID_WIDTH           = 1,
    parameter  int unsigned TDEST_WIDTH         = 1,
    parameter  int unsigned TUSER_WIDTH         = 1,
    parameter  int unsigned MAX_FRAG_SIZE       = 2048,
    localparam int unsigned MAX_FRAG_SIZE_WIDTH = $clog2(MAX_FRAG_SIZE)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [N_SRC-1:0]                              src_en_i,
    input  logic [N_SRC*(MAX_FRAG_SIZE_WIDTH+1)-1:0]      frag_size_i,
    input  logic [N_SRC*TDATA_WIDTH-1:0]                  pkt_i_tdata,
    input  logic [N_SRC*(TDATA_WIDTH/8)-1:0]              pkt_i_tstrb,
    input  logic [N_SRC*(TDATA_WIDTH/8)-1:0]              pkt_i_tkeep,
    input  logic [N_SRC-1:0]                              pkt_i_tlast,
    input  logic [N_SRC*TID_WIDTH-1:0]                    pkt_i_tid,
    input  logic [N_SRC*TDEST_WIDTH-1:0]                  pkt_i_tdest,
    input  logic [N_SRC*TUSER_WIDTH-1:0]                  pkt_i_tuser,
    input  logic [N_SRC-1:0]                              pkt_i_tvalid,
    output logic [N_SRC-1:0]                              pkt_i_tready,
    output logic [TDATA_WIDTH-1:0]                        pkt_o_tdata,
    output logic [TDATA_WIDTH/8-1:0]                      pkt_o_tstrb,
    output logic [TDATA_WIDTH/8-1:0]                      pkt_o_tkeep,
    output logic                                          pkt_o_tlast,
    output logic [TID_WIDTH-1:0]                          pkt_o_tid,
    output logic [TDEST_WIDTH-1:0]                        pkt_o_tdest,
    output logic [TUSER_WIDTH-1:0]                        pkt_o_tuser,
    output logic                                          pkt_o_tvalid,
    input  logic                                          pkt_o_tready,
    output logic [MAX_FRAG_SIZE_WIDTH:0]                  frag_size_o,
    output logic [N_SRC-1:0]                              grant_o,
    output logic                                          busy_o
);

    localparam int unsigned IDX_W  = $clog2(N_SRC);
    localparam int unsigned FS_W   = MAX_FRAG_SIZE_WIDTH + 1;
    localparam int unsigned KEEP_W = TDATA_WIDTH / 8;

    typedef enum logic {IDLE, PASS} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_SRC-1:0]   r_grant;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_last_grant;
    logic [FS_W-1:0]    r_frag_size;

    logic [N_SRC-1:0]   w_req;
    logic               w_lo_vld;
    logic [IDX_W-1:0]   w_lo_idx;
    logic               w_hi_vld;
    logic [IDX_W-1:0]   w_hi_idx;
    logic               w_sel_vld;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_pkt_done;

    // Rotated priority search: the lowest requester above last_grant wins,
    // otherwise the lowest requester overall (the wrap-around case).
    always_comb begin
        w_req    = pkt_i_tvalid & src_en_i;
        w_lo_vld = 1'b0;
        w_lo_idx = '0;
        w_hi_vld = 1'b0;
        w_hi_idx = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (w_req[IDX_W'(i - 1)]) begin
                w_lo_vld = 1'b1;
                w_lo_idx = IDX_W'(i - 1);
                if (IDX_W'(i - 1) > r_last_grant) begin
                    w_hi_vld = 1'b1;
                    w_hi_idx = IDX_W'(i - 1);
                end
            end
        end
        w_sel_vld = w_lo_vld;
        w_sel_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        pkt_o_tdata  = '0;
        pkt_o_tstrb  = '0;
        pkt_o_tkeep  = '0;
        pkt_o_tlast  = 1'b0;
        pkt_o_tid    = '0;
        pkt_o_tdest  = '0;
        pkt_o_tuser  = '0;
        pkt_o_tvalid = 1'b0;
        pkt_i_tready = '0;
        if (r_state == PASS) begin
            pkt_o_tdata  = pkt_i_tdata[r_gidx*TDATA_WIDTH +: TDATA_WIDTH];
            pkt_o_tstrb  = pkt_i_tstrb[r_gidx*KEEP_W +: KEEP_W];
            pkt_o_tkeep  = pkt_i_tkeep[r_gidx*KEEP_W +: KEEP_W];
            pkt_o_tlast  = pkt_i_tlast[r_gidx];
            pkt_o_tid    = pkt_i_tid[r_gidx*TID_WIDTH +: TID_WIDTH];
            pkt_o_tdest  = pkt_i_tdest[r_gidx*TDEST_WIDTH +: TDEST_WIDTH];
            pkt_o_tuser  = pkt_i_tuser[r_gidx*TUSER_WIDTH +: TUSER_WIDTH];
            pkt_o_tvalid = pkt_i_tvalid[r_gidx];
            pkt_i_tready[r_gidx] = pkt_o_tready;
        end
    end

    always_comb begin
        w_pkt_done  = (r_state == PASS) && pkt_o_tvalid && pkt_o_tready && pkt_o_tlast;
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_sel_vld)  w_state_nxt = PASS;
            PASS:    if (w_pkt_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_last_grant <= IDX_W'(N_SRC - 1);
            r_frag_size  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_sel_vld) begin
                r_gidx      <= w_sel_idx;
                r_grant     <= {{(N_SRC-1){1'b0}}, 1'b1} << w_sel_idx;
                r_frag_size <= frag_size_i[w_sel_idx*FS_W +: FS_W];
            end else if (w_pkt_done) begin
                r_last_grant <= r_gidx;
                r_grant      <= '0;
            end
        end
    end

    assign grant_o     = r_grant;
    assign busy_o      = (r_state == PASS);
    assign frag_size_o = r_frag_size;

endmodule

// File: tb/tb_axi4_stream_pkt_arb.sv
// Scoreboard bench for axi4_stream_pkt_arb: per-source expected beat queues plus a
// packet-level round-robin model decide which source should own each output beat.
module tb_axi4_stream_pkt_arb;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int IDW = 2;
    localparam int DSW = 2;
    localparam int UW  = 3;
    localparam int MFS = 2048;
    localparam int FSW = $clog2(MFS) + 1;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [KW-1:0]  strb;
        logic [KW-1:0]  keep;
        logic           last;
        logic [IDW-1:0] id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_i;
    logic [N-1:0]         tb_valid;
    logic [N-1:0]         tb_en;
    logic                 tb_ready;
    beat_t                tb_beat [N];
    logic [FSW-1:0]       tb_frag [N];

    logic [N*FSW-1:0]     frag_size_i;
    logic [N*DW-1:0]      pkt_i_tdata;
    logic [N*KW-1:0]      pkt_i_tstrb;
    logic [N*KW-1:0]      pkt_i_tkeep;
    logic [N-1:0]         pkt_i_tlast;
    logic [N*IDW-1:0]     pkt_i_tid;
    logic [N*DSW-1:0]     pkt_i_tdest;
    logic [N*UW-1:0]      pkt_i_tuser;
    logic [N-1:0]         pkt_i_tready;
    logic [DW-1:0]        pkt_o_tdata;
    logic [KW-1:0]        pkt_o_tstrb;
    logic [KW-1:0]        pkt_o_tkeep;
    logic                 pkt_o_tlast;
    logic [IDW-1:0]       pkt_o_tid;
    logic [DSW-1:0]       pkt_o_tdest;
    logic [UW-1:0]        pkt_o_tuser;
    logic                 pkt_o_tvalid;
    logic [FSW-1:0]       frag_size_o;
    logic [N-1:0]         grant_o;
    logic                 busy_o;

    always_comb begin
        frag_size_i = '0;
        pkt_i_tdata = '0;
        pkt_i_tstrb = '0;
        pkt_i_tkeep = '0;
        pkt_i_tlast = '0;
        pkt_i_tid   = '0;
        pkt_i_tdest = '0;
        pkt_i_tuser = '0;
        for (int k = 0; k < N; k++) begin
            frag_size_i[k*FSW +: FSW] = tb_frag[k];
            pkt_i_tdata[k*DW +: DW]   = tb_beat[k].data;
            pkt_i_tstrb[k*KW +: KW]   = tb_beat[k].strb;
            pkt_i_tkeep[k*KW +: KW]   = tb_beat[k].keep;
            pkt_i_tlast[k]            = tb_beat[k].last;
            pkt_i_tid[k*IDW +: IDW]   = tb_beat[k].id;
            pkt_i_tdest[k*DSW +: DSW] = tb_beat[k].dest;
            pkt_i_tuser[k*UW +: UW]   = tb_beat[k].user;
        end
    end

    axi4_stream_pkt_arb #(
        .N_SRC         (N),
        .TDATA_WIDTH   (DW),
        .TID_WIDTH     (IDW),
        .TDEST_WIDTH   (DSW),
        .TUSER_WIDTH   (UW),
        .MAX_FRAG_SIZE (MFS)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .src_en_i     (tb_en),
        .frag_size_i  (frag_size_i),
        .pkt_i_tdata  (pkt_i_tdata),
        .pkt_i_tstrb  (pkt_i_tstrb),
        .pkt_i_tkeep  (pkt_i_tkeep),
        .pkt_i_tlast  (pkt_i_tlast),
        .pkt_i_tid    (pkt_i_tid),
        .pkt_i_tdest  (pkt_i_tdest),
        .pkt_i_tuser  (pkt_i_tuser),
        .pkt_i_tvalid (tb_valid),
        .pkt_i_tready (pkt_i_tready),
        .pkt_o_tdata  (pkt_o_tdata),
        .pkt_o_tstrb  (pkt_o_tstrb),
        .pkt_o_tkeep  (pkt_o_tkeep),
        .pkt_o_tlast  (pkt_o_tlast),
        .pkt_o_tid    (pkt_o_tid),
        .pkt_o_tdest  (pkt_o_tdest),
        .pkt_o_tuser  (pkt_o_tuser),
        .pkt_o_tvalid (pkt_o_tvalid),
        .pkt_o_tready (tb_ready),
        .frag_size_o  (frag_size_o),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
    );

    beat_t       drv_q [N][$];
    beat_t       exp_q [N][$];
    int          total = 0;
    int          bad = 0;
    int          gap_pct = 0;
    int unsigned hs_cnt [N];
    int          cyc = 0;
    bit          arm = 1'b0;
    int          first_req_cyc = 0;
    int          last_hs_cyc = 0;
    int          dut_order [$];
    int          frag_log [$];
    bit          m_pass = 1'b0;
    int          m_g = 0;
    int          m_last = N - 1;
    logic [FSW-1:0] m_frag = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input int k, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            b.strb = KW'($urandom);
            b.keep = KW'($urandom);
            b.last = (i == len - 1);
            b.id   = IDW'($urandom);
            b.dest = DSW'($urandom);
            b.user = UW'($urandom);
            drv_q[k].push_back(b);
            exp_q[k].push_back(b);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            if (req[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = (r == -1) ? i : -2;
        end
        return r;
    endfunction

    function automatic bit all_idle();
        for (int k = 0; k < N; k++) begin
            if (drv_q[k].size() != 0) return 1'b0;
        end
        return !m_pass;
    endfunction

    task automatic wait_hs(input int k, input int unsigned target, input string name);
        for (int i = 0; i < 300 && hs_cnt[k] < target; i++) @(negedge clk);
        chk(name, 64'(hs_cnt[k] >= target), 64'd1);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int i = 0; i < budget && !all_idle(); i++) @(negedge clk);
        chk(name, 64'(all_idle()), 64'd1);
        @(posedge clk);
        #2;
    endtask

    // Source drivers: hold tvalid until accepted, optional idle gaps between beats.
    initial begin
        logic [N-1:0] hs;
        tb_valid = '0;
        for (int k = 0; k < N; k++) tb_beat[k] = '0;
        forever begin
            @(negedge clk);
            hs = tb_valid & pkt_i_tready;
            @(posedge clk);
            #1;
            if (rst_i) begin
                tb_valid = '0;
                continue;
            end
            for (int k = 0; k < N; k++) begin
                if (hs[k]) begin
                    void'(drv_q[k].pop_front());
                    tb_valid[k] = 1'b0;
                end
                if (!tb_valid[k] && drv_q[k].size() > 0 && $urandom_range(99) >= gap_pct) begin
                    tb_valid[k] = 1'b1;
                    tb_beat[k]  = drv_q[k][0];
                end
            end
        end
    end

    // Monitor and packet-level reference model.
    initial begin
        logic [N-1:0] req;
        logic [N-1:0] exp_rdy;
        beat_t        e;
        beat_t        a;
        bit           prev_busy;
        int           c;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_i) begin
                chk("rst_grant", 64'(grant_o), 64'd0);
                chk("rst_busy", 64'(busy_o), 64'd0);
                chk("rst_frag", 64'(frag_size_o), 64'd0);
                chk("rst_tvalid", 64'(pkt_o_tvalid), 64'd0);
                chk("rst_tready", 64'(pkt_i_tready), 64'd0);
                m_pass    = 1'b0;
                m_last    = N - 1;
                prev_busy = 1'b0;
                continue;
            end
            req = tb_valid & tb_en;
            if (arm && req != '0) begin
                first_req_cyc = cyc;
                arm = 1'b0;
            end
            if (busy_o && !prev_busy) begin
                dut_order.push_back(onehot_idx(grant_o));
                frag_log.push_back(int'(frag_size_o));
            end
            prev_busy = busy_o;

            exp_rdy = (m_pass && tb_ready) ? (N'(1) << m_g) : '0;
            chk("grant", 64'(grant_o), m_pass ? 64'(N'(1) << m_g) : 64'd0);
            chk("busy", 64'(busy_o), 64'(m_pass));
            chk("out_tvalid", 64'(pkt_o_tvalid), 64'(m_pass && tb_valid[m_g]));
            chk("in_tready", 64'(pkt_i_tready), 64'(exp_rdy));

            if (m_pass) begin
                chk("frag_hold", 64'(frag_size_o), 64'(m_frag));
                if (tb_valid[m_g]) begin
                    if (exp_q[m_g].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL beat_src%0d: got output beat, expected none queued", m_g);
                    end else begin
                        e = exp_q[m_g][0];
                        a.data = pkt_o_tdata;
                        a.strb = pkt_o_tstrb;
                        a.keep = pkt_o_tkeep;
                        a.last = pkt_o_tlast;
                        a.id   = pkt_o_tid;
                        a.dest = pkt_o_tdest;
                        a.user = pkt_o_tuser;
                        chk("beat", 64'(a), 64'(e));
                        if (tb_ready) begin
                            void'(exp_q[m_g].pop_front());
                            hs_cnt[m_g]++;
                            last_hs_cyc = cyc;
                            if (e.last) begin
                                m_pass = 1'b0;
                                m_last = m_g;
                            end
                        end
                    end
                end
            end else begin
                c = pick(req, m_last);
                if (c >= 0) begin
                    m_pass = 1'b1;
                    m_g    = c;
                    m_frag = tb_frag[c];
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        rst_i    = 1'b1;
        tb_en    = '1;
        tb_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            tb_frag[k] = FSW'(10 * (k + 1));
            hs_cnt[k]  = 0;
        end
        repeat (3) @(posedge clk);
        #2;
        rst_i = 1'b0;
        @(posedge clk);
        #2;

        // All four sources request together: strict 0,1,2,3 with one bubble each.
        dut_order.delete();
        arm = 1'b1;
        for (int k = 0; k < N; k++) push_pkt(k, 3);
        wait_drain(200, "drain_fair");
        chk("fair_count", 64'(dut_order.size()), 64'd4);
        for (int i = 0; i < 4 && i < dut_order.size(); i++) chk("fair_order", 64'(dut_order[i]), 64'(i));
        chk("fair_cycles", 64'(last_hs_cyc - first_req_cyc + 1), 64'd16);

        // Fragment size latched at grant, mid-packet change only seen by next grant.
        frag_log.delete();
        tb_frag[2] = FSW'(100);
        base = hs_cnt[2];
        push_pkt(2, 4);
        push_pkt(2, 2);
        wait_hs(2, base + 1, "frag_first_beat");
        tb_frag[2] = FSW'(50);
        wait_drain(200, "drain_frag");
        chk("frag_log_count", 64'(frag_log.size()), 64'd2);
        if (frag_log.size() == 2) begin
            chk("frag_first", 64'(frag_log[0]), 64'd100);
            chk("frag_second", 64'(frag_log[1]), 64'd50);
        end

        // Enable dropped mid-packet: packet finishes, no new grant while disabled.
        base = hs_cnt[1];
        push_pkt(1, 4);
        push_pkt(1, 2);
        wait_hs(1, base + 1, "en_first_beat");
        tb_en[1] = 1'b0;
        wait_hs(1, base + 4, "en_pkt_done");
        repeat (20) @(posedge clk);
        #2;
        chk("en_no_regrant", 64'(hs_cnt[1]), 64'(base + 4));
        chk("en_idle_grant", 64'(grant_o), 64'd0);
        tb_en[1] = 1'b1;
        wait_drain(200, "drain_en");

        // Downstream back-pressure for five cycles mid-packet.
        base = hs_cnt[0];
        push_pkt(0, 4);
        wait_hs(0, base + 1, "bp_first_beat");
        tb_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("bp_stalled", 64'(hs_cnt[0]), 64'(base + 1));
        chk("bp_grant_held", 64'(grant_o), 64'd1);
        tb_ready = 1'b1;
        wait_drain(200, "drain_bp");
        chk("bp_done", 64'(hs_cnt[0]), 64'(base + 4));

        // Asynchronous reset during a packet, then source 0 must win against 3.
        base = hs_cnt[3];
        push_pkt(3, 5);
        wait_hs(3, base + 1, "rst_first_beat");
        rst_i = 1'b1;
        #1;
        chk("arst_grant", 64'(grant_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_tvalid", 64'(pkt_o_tvalid), 64'd0);
        chk("arst_tready", 64'(pkt_i_tready), 64'd0);
        @(posedge clk);
        #2;
        for (int k = 0; k < N; k++) begin
            drv_q[k].delete();
            exp_q[k].delete();
        end
        push_pkt(3, 2);
        push_pkt(0, 2);
        dut_order.delete();
        @(posedge clk);
        #2;
        rst_i = 1'b0;
        wait_drain(200, "drain_rst");
        chk("rst_order_count", 64'(dut_order.size()), 64'd2);
        if (dut_order.size() == 2) begin
            chk("rst_first", 64'(dut_order[0]), 64'd0);
            chk("rst_second", 64'(dut_order[1]), 64'd3);
        end

        // Randomized traffic: gaps, back-pressure, enable toggles, size changes.
        gap_pct = 30;
        repeat (1500) begin
            @(posedge clk);
            #2;
            for (int k = 0; k < N; k++) begin
                if (drv_q[k].size() < 10 && $urandom_range(99) < 8) push_pkt(k, int'($urandom_range(6, 1)));
                if ($urandom_range(99) < 3) tb_en[k] = ~tb_en[k];
                if ($urandom_range(99) < 5) tb_frag[k] = FSW'($urandom_range(MFS, 1));
            end
            tb_ready = ($urandom_range(99) < 75);
        end
        tb_en    = '1;
        tb_ready = 1'b1;
        wait_drain(3000, "drain_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
